// File: rtl/mimo_delay_line.sv
// Multi-channel valid-gated circular-buffer delay line with a shared write pointer; output qualified once the line has filled.
// Optional: define DLY_ERR_EN to add a sticky cfg_err output for out-of-range delay loads.
module mimo_delay_line #(
    parameter  int NUM_CH        = 4,
    parameter  int DATA_WIDTH    = 13,
    parameter  int MAX_DEPTH     = 32,
    parameter  int DEFAULT_DELAY = 31,
    localparam int DLY_W         = $clog2(MAX_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    input  logic                         valid,
    input  logic [DLY_W-1:0]             delay,
    input  logic                         delay_load,
    input  logic                         flush,
    output logic [NUM_CH*DATA_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         primed
`ifdef DLY_ERR_EN
    ,
    output logic                         cfg_err
`endif
);
    localparam int W  = NUM_CH * DATA_WIDTH;
    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [DLY_W-1:0] MAXD = DLY_W'(MAX_DEPTH);

    logic [W-1:0]     r_mem [MAX_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [DLY_W-1:0] r_fill_cnt;
    logic [DLY_W-1:0] r_cur_delay;
    logic [W-1:0]     r_dout;
    logic             r_dout_valid;

    logic             w_advance;
    logic             w_primed;
    logic             w_dly_bad;
    logic [DLY_W-1:0] w_dly_clamped;
    logic [AW-1:0]    w_rd_ptr;
    logic [W-1:0]     w_rd_dat;

    assign w_advance     = valid & ~flush & ~delay_load;
    assign w_primed      = (r_fill_cnt >= r_cur_delay);
    assign w_dly_bad     = (delay > MAXD);
    assign w_dly_clamped = w_dly_bad ? MAXD : delay;
    // Delay of MAX_DEPTH aliases to rd == wr_ptr: the oldest entry, read before this edge overwrites it.
    assign w_rd_ptr      = r_wr_ptr - r_cur_delay[AW-1:0];
    assign w_rd_dat      = r_mem[w_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_fill_cnt   <= '0;
            r_cur_delay  <= DLY_W'(DEFAULT_DELAY);
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (flush || delay_load) begin
            r_fill_cnt   <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            if (flush) begin
                r_wr_ptr <= '0;
            end
            if (delay_load) begin
                r_cur_delay <= w_dly_clamped;
            end
        end else if (valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_fill_cnt != MAXD) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            if (w_primed) begin
                r_dout       <= (r_cur_delay == '0) ? din : w_rd_dat;
                r_dout_valid <= 1'b1;
            end else begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
            end
        end else begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign primed     = w_primed;

`ifdef DLY_ERR_EN
    logic r_cfg_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else if (flush) begin
            r_cfg_err <= 1'b0;
        end else if (delay_load && w_dly_bad) begin
            r_cfg_err <= 1'b1;
        end
    end

    assign cfg_err = r_cfg_err;
`endif
endmodule

// File: tb/tb_mimo_delay_line.sv
// Bench for mimo_delay_line: randomized stimulus against a queue-based model of "output = sample D accepted beats ago".
module tb_mimo_delay_line;
    localparam int NCH  = 4;
    localparam int DW   = 13;
    localparam int MAXD = 32;
    localparam int DEFD = 31;
    localparam int W    = NCH * DW;
    localparam int DLYW = $clog2(MAXD + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    din = '0;
    logic            valid = 1'b0;
    logic [DLYW-1:0] delay = '0;
    logic            delay_load = 1'b0;
    logic            flush = 1'b0;
    logic [W-1:0]    dout;
    logic            dout_valid;
    logic            primed;
`ifdef DLY_ERR_EN
    logic            cfg_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: samples accepted since the last re-prime, newest at the back.
    logic [W-1:0] hist[$];
    int           m_delay;
    logic [W-1:0] m_dout;
    logic         m_vld;
    logic         m_primed;
    logic         m_err;

    mimo_delay_line #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_DEPTH(MAXD), .DEFAULT_DELAY(DEFD)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .valid(valid), .delay(delay),
        .delay_load(delay_load), .flush(flush), .dout(dout),
        .dout_valid(dout_valid), .primed(primed)
`ifdef DLY_ERR_EN
        , .cfg_err(cfg_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_din();
        logic [W-1:0] d;
        for (int k = 0; k < NCH; k++) d[k*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_delay  = DEFD;
        m_dout   = '0;
        m_vld    = 1'b0;
        m_err    = 1'b0;
        m_primed = (DEFD == 0);
    endtask

    // Drives one clock cycle and advances the model; samples are compared by the caller 1ns after the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic fl,
                        input logic ld, input int dl);
        valid = v; din = d; flush = fl; delay_load = ld; delay = DLYW'(dl);
        if (fl || ld) begin
            if (ld) m_delay = (dl > MAXD) ? MAXD : dl;
            if (ld && dl > MAXD) m_err = 1'b1;
            if (fl) m_err = 1'b0;
            hist.delete();
            m_dout = '0;
            m_vld  = 1'b0;
        end else if (v) begin
            if (hist.size() >= m_delay) begin
                m_dout = (m_delay == 0) ? d : hist[hist.size() - m_delay];
                m_vld  = 1'b1;
            end else begin
                m_dout = '0;
                m_vld  = 1'b0;
            end
            hist.push_back(d);
            if (hist.size() > MAXD) void'(hist.pop_front());
        end else begin
            m_vld = 1'b0;
        end
        m_primed = (hist.size() >= m_delay);
        @(posedge clk);
        #1;
        valid = 1'b0; flush = 1'b0; delay_load = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({dout_valid, primed, dout} !== {1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_outputs got vld=%b primed=%b dout=%h exp 0/0/0", dout_valid, primed, dout);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_default_fill();
        logic [W-1:0] d;
        logic [W-1:0] first_exp;
        int first_beat = -1;
        for (int k = 0; k < NCH; k++) first_exp[k*DW +: DW] = DW'(100 * k);
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NCH; k++) d[k*DW +: DW] = DW'(100 * k + n);
            step(1'b1, d, 1'b0, 1'b0, 0);
            checks++;
            if ({dout_valid, primed, dout} !== {m_vld, m_primed, m_dout}) begin
                errors++;
                $display("FAIL default_fill beat %0d got %b/%b/%h exp %b/%b/%h", n, dout_valid, primed, dout, m_vld, m_primed, m_dout);
            end
            if (dout_valid && first_beat < 0) begin
                first_beat = n;
                checks++;
                if (dout !== first_exp) begin
                    errors++;
                    $display("FAIL default_first_sample got %h exp %h", dout, first_exp);
                end
            end
        end
        checks++;
        if (first_beat != DEFD) begin
            errors++;
            $display("FAIL default_first_valid_beat got %0d exp %0d", first_beat, DEFD);
        end
    endtask

    task automatic test_gapped();
        int pulses = 0;
        step(1'b0, '0, 1'b0, 1'b1, 5);
        for (int c = 0; c < 60; c++) begin
            step((c % 3) == 0, rand_din(), 1'b0, 1'b0, 0);
            if (dout_valid) pulses++;
            checks++;
            if ({dout_valid, primed, dout} !== {m_vld, m_primed, m_dout}) begin
                errors++;
                $display("FAIL gapped cycle %0d got %b/%b/%h exp %b/%b/%h", c, dout_valid, primed, dout, m_vld, m_primed, m_dout);
            end
        end
        checks++;
        if (pulses != 15) begin
            errors++;
            $display("FAIL gapped_pulse_count got %0d exp 15", pulses);
        end
    endtask

    task automatic test_zero_delay();
        step(1'b0, '0, 1'b0, 1'b1, 0);
        checks++;
        if (primed !== 1'b1) begin
            errors++;
            $display("FAIL zero_delay_primed got %b exp 1", primed);
        end
        for (int n = 0; n < 6; n++) begin
            step(1'b1, rand_din(), 1'b0, 1'b0, 0);
            checks++;
            if ({dout_valid, dout} !== {1'b1, din}) begin
                errors++;
                $display("FAIL zero_delay beat %0d got %b/%h exp 1/%h", n, dout_valid, dout, din);
            end
        end
    endtask

    task automatic test_max_delay();
        logic [W-1:0] d0 = '0;
        step(1'b0, '0, 1'b0, 1'b1, MAXD);
        for (int n = 0; n < 40; n++) begin
            step(1'b1, rand_din(), 1'b0, 1'b0, 0);
            if (n == 0) d0 = din;
            checks++;
            if ({dout_valid, primed, dout} !== {m_vld, m_primed, m_dout}) begin
                errors++;
                $display("FAIL max_delay beat %0d got %b/%b/%h exp %b/%b/%h", n, dout_valid, primed, dout, m_vld, m_primed, m_dout);
            end
            if (n == MAXD) begin
                checks++;
                if ({dout_valid, dout} !== {1'b1, d0}) begin
                    errors++;
                    $display("FAIL max_delay_wrap got %b/%h exp 1/%h", dout_valid, dout, d0);
                end
            end
        end
    endtask

    task automatic test_flush();
        int wait_beats = 0;
        step(1'b0, '0, 1'b0, 1'b1, 4);
        for (int n = 0; n < 10; n++) step(1'b1, rand_din(), 1'b0, 1'b0, 0);
        step(1'b1, rand_din(), 1'b1, 1'b0, 0);
        checks++;
        if ({dout_valid, primed, dout} !== {1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("FAIL flush_clear got %b/%b/%h exp 0/0/0", dout_valid, primed, dout);
        end
        while (!dout_valid && wait_beats < 20) begin
            step(1'b1, rand_din(), 1'b0, 1'b0, 0);
            wait_beats++;
            checks++;
            if ({dout_valid, primed, dout} !== {m_vld, m_primed, m_dout}) begin
                errors++;
                $display("FAIL flush_refill beat %0d got %b/%b/%h exp %b/%b/%h", wait_beats, dout_valid, primed, dout, m_vld, m_primed, m_dout);
            end
        end
        checks++;
        if (wait_beats != 5) begin
            errors++;
            $display("FAIL flush_first_valid got %0d beats exp 5", wait_beats);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, '0, 1'b0, 1'b1, 3);
        for (int n = 0; n < 8; n++) step(1'b1, rand_din(), 1'b0, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({dout_valid, primed, dout} !== {1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("FAIL async_reset got %b/%b/%h exp 0/0/0", dout_valid, primed, dout);
        end
        #1 rst = 1'b0;
        for (int n = 0; n < DEFD + 3; n++) begin
            step(1'b1, rand_din(), 1'b0, 1'b0, 0);
            checks++;
            if ({dout_valid, primed, dout} !== {m_vld, m_primed, m_dout}) begin
                errors++;
                $display("FAIL post_reset beat %0d got %b/%b/%h exp %b/%b/%h", n, dout_valid, primed, dout, m_vld, m_primed, m_dout);
            end
        end
`ifdef DLY_ERR_EN
        step(1'b0, '0, 1'b0, 1'b1, 40);
        for (int n = 0; n < MAXD + 2; n++) begin
            step(1'b1, rand_din(), 1'b0, 1'b0, 0);
            checks++;
            if ({cfg_err, dout_valid, primed, dout} !== {m_err, m_vld, m_primed, m_dout}) begin
                errors++;
                $display("FAIL cfg_err_clamp beat %0d got %b/%b/%b/%h exp %b/%b/%b/%h", n, cfg_err, dout_valid, primed, dout, m_err, m_vld, m_primed, m_dout);
            end
        end
        step(1'b0, '0, 1'b1, 1'b0, 0);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_flush got %b exp 0", cfg_err);
        end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic fl = ($urandom_range(0, 59) == 0);
            logic ld = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 3) != 0, rand_din(), fl, ld, $urandom_range(0, 40));
            checks++;
            if ({dout_valid, primed, dout} !== {m_vld, m_primed, m_dout}) begin
                errors++;
                $display("FAIL random cycle %0d got %b/%b/%h exp %b/%b/%h", c, dout_valid, primed, dout, m_vld, m_primed, m_dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_fill();
        test_gapped();
        test_zero_delay();
        test_max_delay();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
